// File: rtl/spike_event_queue.sv
// spike_event_queue
//
// Buffers presynaptic spike events from two never-stalling producers (external
// input spikes and recurrent feedback spikes) in one circular FIFO and presents
// them one at a time on the network controller's occurred/index/ack handshake.
// Events that do not fit are dropped and counted.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   flush          synchronous queue clear (counters and sticky flag kept)
//   ext_valid      external spike this cycle
//   ext_index      synapse row of the external spike
//   fb_valid       feedback spike this cycle
//   fb_neuron      index of the spiking neuron
//   input_occurred queue non-empty, head valid
//   input_index    head entry (0 when empty)
//   input_ack      controller took the head; pop
//   count          current occupancy
//   drop_count     saturating count of dropped events
//   ack_err        sticky: ack seen while empty
module spike_event_queue #(
    parameter int unsigned SR_DEPTH = 16384,
    parameter int unsigned NR_DEPTH = 16,
    parameter int unsigned Q_DEPTH  = 8,
    parameter int unsigned FB_BASE  = 16368,
    parameter int unsigned DROP_W   = 16,
    localparam int unsigned SW = $clog2(SR_DEPTH),
    localparam int unsigned NW = $clog2(NR_DEPTH),
    localparam int unsigned CW = $clog2(Q_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ext_valid,
    input  logic [SW-1:0]     ext_index,
    input  logic              fb_valid,
    input  logic [NW-1:0]     fb_neuron,
    output logic              input_occurred,
    output logic [SW-1:0]     input_index,
    input  logic              input_ack,
    output logic [CW-1:0]     count,
    output logic [DROP_W-1:0] drop_count,
    output logic              ack_err
);

    localparam int unsigned PW = $clog2(Q_DEPTH);

    logic [SW-1:0]     mem [Q_DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q;
    logic [DROP_W-1:0] drop_q;
    logic              ack_err_q;

    logic              pop;
    logic [CW-1:0]     free;
    logic              acc_ext, acc_fb;
    logic [1:0]        n_valid, n_acc, n_drop;
    logic [SW-1:0]     fb_idx;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_d;

    always_comb begin
        pop    = input_ack && (count_q != '0);
        // A pop in the same cycle frees a slot for this cycle's pushes.
        free   = CW'(Q_DEPTH) - count_q + CW'(pop);
        fb_idx = SW'(FB_BASE) + SW'(fb_neuron);

        acc_ext = 1'b0;
        acc_fb  = 1'b0;
        if (free >= CW'(2)) begin
            acc_ext = ext_valid;
            acc_fb  = fb_valid;
        end else if (free == CW'(1)) begin
            // ext is the older event, so it wins the last slot.
            acc_ext = ext_valid;
            acc_fb  = fb_valid && !ext_valid;
        end

        n_valid  = {1'b0, ext_valid} + {1'b0, fb_valid};
        n_acc    = {1'b0, acc_ext} + {1'b0, acc_fb};
        n_drop   = n_valid - n_acc;
        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(n_drop);
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            if (input_ack && (count_q == '0)) begin
                ack_err_q <= 1'b1;
            end
            if (flush) begin
                // Discarded pushes are not drops, so drop_q is left alone.
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_q + PW'(pop);
                wr_ptr_q <= wr_ptr_q + PW'(n_acc);
                count_q  <= count_q + CW'(n_acc) - CW'(pop);
                drop_q   <= drop_d;
            end
        end
    end

    // Storage needs no reset: reads are masked while count is zero.
    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            if (acc_ext) begin
                mem[wr_ptr_q] <= ext_index;
            end
            if (acc_fb) begin
                mem[wr_ptr_q + PW'(acc_ext)] <= fb_idx;
            end
        end
    end

    assign input_occurred = (count_q != '0);
    assign input_index    = input_occurred ? mem[rd_ptr_q] : '0;
    assign count          = count_q;
    assign drop_count     = drop_q;
    assign ack_err        = ack_err_q;

    a_count_bound : assert property (@(posedge clk) disable iff (!reset)
        count_q <= CW'(Q_DEPTH));

    a_head_stable : assert property (@(posedge clk) disable iff (!reset)
        (input_occurred && !input_ack && !flush) |=> $stable(input_index));

endmodule
